// File: rtl/ls161_cascade_pkg.sv
// Shared constants and helpers for the cascaded LS161 counter chain.
// The period helper is used by benches to derive the auto-reload cycle length.
package ls161_cascade_pkg;

    localparam int unsigned StageWidth = 4;
    localparam int unsigned MaxStages  = 8;

    // Cycles between successive reload values with both enables held high.
    function automatic longint unsigned mod_period(input int unsigned     width,
                                                   input longint unsigned reload);
        return (64'd1 << width) - reload;
    endfunction

endpackage

// File: rtl/ls161_cascade_ls161.sv
// One 74LS161 synchronous 4-bit binary counter stage with pin-level semantics.
// Clear is asynchronous; load beats count; RCO is purely combinational.
module ls161
    import ls161_cascade_pkg::*;
(
    input  logic                  CLK,
    input  logic                  CLR_n,
    input  logic                  LOAD_n,
    input  logic                  ENP,
    input  logic                  ENT,
    input  logic [StageWidth-1:0] D,
    output logic [StageWidth-1:0] Q,
    output logic                  RCO
);

    logic [StageWidth-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (!LOAD_n) begin
            q_d = D;
        end else if (ENP && ENT) begin
            q_d = q_q + StageWidth'(1);
        end
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q   = q_q;
    assign RCO = ENT & (q_q == {StageWidth{1'b1}});

endmodule

// File: rtl/ls161_cascade.sv
// Chain of LS161 stages with a combinational carry, optional terminal-count
// auto-reload, and a 2-bit select tap for the downstream LS139 decoder.
module ls161_cascade
    import ls161_cascade_pkg::*;
#(
    parameter int unsigned             STAGES       = 3,
    parameter bit                      AUTO_RELOAD  = 1'b0,
    parameter logic [4*STAGES-1:0]     RELOAD_VALUE = '0,
    parameter int unsigned             SEL_LSB      = 0
) (
    input  logic                  CLK,
    input  logic                  CLR_n,
    input  logic                  LOAD_n,
    input  logic                  ENP,
    input  logic                  ENT,
    input  logic [4*STAGES-1:0]   D,
    output logic [4*STAGES-1:0]   Q,
    output logic                  RCO,
    output logic [1:0]            SEL
);

    localparam int unsigned Width = StageWidth * STAGES;

    logic             load_int_n;
    logic [Width-1:0] load_data;

    // External load wins the data mux; the reload value is used only for terminal count.
    assign load_int_n = LOAD_n & ~(AUTO_RELOAD & RCO);
    assign load_data  = LOAD_n ? RELOAD_VALUE : D;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic ent_k;
        logic rco_k;

        if (k == 0) begin : g_first
            assign ent_k = ENT;
        end else begin : g_next
            assign ent_k = g_stage[k-1].rco_k;
        end

        ls161 u_stage (
            .CLK    (CLK),
            .CLR_n  (CLR_n),
            .LOAD_n (load_int_n),
            .ENP    (ENP),
            .ENT    (ent_k),
            .D      (load_data[StageWidth*k +: StageWidth]),
            .Q      (Q[StageWidth*k +: StageWidth]),
            .RCO    (rco_k)
        );
    end

    assign RCO = g_stage[STAGES-1].rco_k;
    assign SEL = Q[SEL_LSB +: 2];

endmodule

// File: tb/tb_ls161_cascade.sv
// Bench for ls161_cascade: a plain wrap-around chain and an auto-reload chain
// share stimulus and are checked against whole-word arithmetic models.
module tb_ls161_cascade;
    import ls161_cascade_pkg::*;

    logic        CLK = 1'b0;
    logic        CLR_n, LOAD_n, ENP, ENT;
    logic [11:0] D;
    logic [11:0] q_p, q_a;
    logic        rco_p, rco_a;
    logic [1:0]  sel_p, sel_a;

    int m_p, m_a;
    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    ls161_cascade #(
        .STAGES       (3),
        .AUTO_RELOAD  (1'b0),
        .RELOAD_VALUE (12'h000),
        .SEL_LSB      (4)
    ) dut_plain (
        .CLK    (CLK),
        .CLR_n  (CLR_n),
        .LOAD_n (LOAD_n),
        .ENP    (ENP),
        .ENT    (ENT),
        .D      (D),
        .Q      (q_p),
        .RCO    (rco_p),
        .SEL    (sel_p)
    );

    ls161_cascade #(
        .STAGES       (3),
        .AUTO_RELOAD  (1'b1),
        .RELOAD_VALUE (12'hF00),
        .SEL_LSB      (0)
    ) dut_ar (
        .CLK    (CLK),
        .CLR_n  (CLR_n),
        .LOAD_n (LOAD_n),
        .ENP    (ENP),
        .ENT    (ENT),
        .D      (D),
        .Q      (q_a),
        .RCO    (rco_a),
        .SEL    (sel_a)
    );

    // Next counter value from the block-level rules, using plain 12-bit arithmetic.
    function automatic int next_val(input int m, input bit ar);
        bit terminal;
        terminal = ENT && (m == 4095);
        if (!LOAD_n)           return int'(D);
        if (ar && terminal)    return 'hF00;
        if (ENP && ENT)        return (m + 1) % 4096;
        return m;
    endfunction

    function automatic bit exp_rco(input int m);
        return ENT && (m == 4095);
    endfunction

    task automatic tick();
        @(posedge CLK);
        if (CLR_n) begin
            m_p = next_val(m_p, 1'b0);
            m_a = next_val(m_a, 1'b1);
        end else begin
            m_p = 0;
            m_a = 0;
        end
        @(negedge CLK);
    endtask

    task automatic load_word(input logic [11:0] v);
        LOAD_n = 1'b0;
        D      = v;
        tick();
        LOAD_n = 1'b1;
    endtask

    task automatic test_reset();
        CLR_n = 1'b0; LOAD_n = 1'b0; ENP = 1'b1; ENT = 1'b1; D = 12'hABC;
        m_p = 0; m_a = 0;
        repeat (3) tick();
        checks++;
        if (q_p !== 12'h000 || rco_p !== 1'b0 || sel_p !== 2'd0)
            begin failures++; $display("FAIL reset_plain q=%h rco=%b sel=%0d want 000/0/0", q_p, rco_p, sel_p); end
        checks++;
        if (q_a !== 12'h000 || rco_a !== 1'b0 || sel_a !== 2'd0)
            begin failures++; $display("FAIL reset_ar q=%h rco=%b sel=%0d want 000/0/0", q_a, rco_a, sel_a); end
        CLR_n = 1'b1; LOAD_n = 1'b1;
        tick();
        checks++;
        if (q_p !== 12'h001 || q_a !== 12'h001)
            begin failures++; $display("FAIL reset_release plain=%h ar=%h want 001", q_p, q_a); end
    endtask

    task automatic test_chain_carry();
        ENP = 1'b1; ENT = 1'b1;
        load_word(12'h0FE);
        tick();
        checks++;
        if (q_p !== 12'h0FF || rco_p !== 1'b0)
            begin failures++; $display("FAIL chain_0ff q=%h rco=%b want 0ff/0", q_p, rco_p); end
        tick();
        checks++;
        if (q_p !== 12'h100 || q_a !== 12'h100)
            begin failures++; $display("FAIL chain_100 plain=%h ar=%h want 100", q_p, q_a); end
        load_word(12'hFFE);
        tick();
        checks++;
        if (q_p !== 12'hFFF || rco_p !== 1'b1 || rco_a !== 1'b1)
            begin failures++; $display("FAIL chain_fff q=%h rco=%b/%b want fff/1/1", q_p, rco_p, rco_a); end
        tick();
        checks++;
        if (q_p !== 12'h000 || rco_p !== 1'b0)
            begin failures++; $display("FAIL chain_wrap q=%h rco=%b want 000/0", q_p, rco_p); end
        checks++;
        if (q_a !== 12'hF00 || rco_a !== 1'b0)
            begin failures++; $display("FAIL chain_reload q=%h rco=%b want f00/0", q_a, rco_a); end
    endtask

    task automatic test_enables();
        ENP = 1'b1; ENT = 1'b1;
        load_word(12'hFFF);
        ENP = 1'b0;
        checks++;
        if (q_p !== 12'hFFF || rco_p !== 1'b1)
            begin failures++; $display("FAIL enp_low_rco q=%h rco=%b want fff/1", q_p, rco_p); end
        tick();
        checks++;
        if (q_p !== 12'hFFF || rco_p !== 1'b1)
            begin failures++; $display("FAIL enp_low_hold q=%h rco=%b want fff/1", q_p, rco_p); end
        checks++;
        if (q_a !== 12'hF00)
            begin failures++; $display("FAIL enp_low_reload q=%h want f00", q_a); end
        ENP = 1'b1; ENT = 1'b0;
        load_word(12'hFFF);
        checks++;
        if (rco_p !== 1'b0 || rco_a !== 1'b0)
            begin failures++; $display("FAIL ent_low_rco rco=%b/%b want 0/0", rco_p, rco_a); end
        tick();
        checks++;
        if (q_p !== 12'hFFF || q_a !== 12'hFFF)
            begin failures++; $display("FAIL ent_low_hold q=%h/%h want fff/fff", q_p, q_a); end
        ENP = 1'b0;
        load_word(12'h123);
        checks++;
        if (q_p !== 12'h123 || q_a !== 12'h123)
            begin failures++; $display("FAIL load_no_enable q=%h/%h want 123", q_p, q_a); end
    endtask

    task automatic test_auto_reload();
        int last = -1;
        int rco_cnt = 0;
        ENP = 1'b1; ENT = 1'b1;
        load_word(12'hF00);
        for (int i = 1; i <= 512; i++) begin
            tick();
            checks++;
            if (q_a !== m_a[11:0] || rco_a !== exp_rco(m_a))
                begin failures++; $display("FAIL ar_seq cyc=%0d q=%h rco=%b want %h/%b", i, q_a, rco_a, m_a[11:0], exp_rco(m_a)); end
            if (rco_a) rco_cnt++;
            if (q_a == 12'hF00) begin
                if (last >= 0) begin
                    checks++;
                    if (longint'(i - last) != longint'(mod_period(12, 64'hF00)))
                        begin failures++; $display("FAIL ar_period got=%0d want=%0d", i - last, mod_period(12, 64'hF00)); end
                end
                last = i;
            end
        end
        checks++;
        if (rco_cnt != 2 || last != 512)
            begin failures++; $display("FAIL ar_rco_count rco=%0d last=%0d want 2/512", rco_cnt, last); end
    endtask

    task automatic test_simultaneous();
        ENP = 1'b1; ENT = 1'b1;
        load_word(12'hFFF);
        load_word(12'h055);
        checks++;
        if (q_p !== 12'h055 || q_a !== 12'h055)
            begin failures++; $display("FAIL ext_load_wins q=%h/%h want 055", q_p, q_a); end
        load_word(12'hFFF);
        LOAD_n = 1'b0; D = 12'h055; CLR_n = 1'b0;
        #1;
        m_p = 0; m_a = 0;
        checks++;
        if (q_p !== 12'h000 || q_a !== 12'h000 || rco_p !== 1'b0)
            begin failures++; $display("FAIL clr_async q=%h/%h rco=%b want 000/000/0", q_p, q_a, rco_p); end
        tick();
        checks++;
        if (q_p !== 12'h000 || q_a !== 12'h000)
            begin failures++; $display("FAIL clr_over_load q=%h/%h want 000", q_p, q_a); end
        CLR_n = 1'b1; LOAD_n = 1'b1;
    endtask

    task automatic test_sel_tap();
        logic [3:0] onehot;
        ENP = 1'b1; ENT = 1'b1;
        load_word(12'h000);
        for (int i = 1; i <= 64; i++) begin
            tick();
            onehot = 4'b0001 << sel_p;
            checks++;
            if (sel_p !== 2'((m_p >> 4) & 3) || onehot !== (4'b0001 << ((m_p >> 4) & 3)))
                begin failures++; $display("FAIL sel_tap cyc=%0d sel=%0d want %0d", i, sel_p, (m_p >> 4) & 3); end
            if (i % 16 == 0) begin
                checks++;
                if (sel_p !== 2'((i / 16) % 4))
                    begin failures++; $display("FAIL sel_step cyc=%0d sel=%0d want %0d", i, sel_p, (i / 16) % 4); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            CLR_n  = ($urandom_range(0, 39) != 0);
            LOAD_n = ($urandom_range(0, 9) != 0);
            ENP    = ($urandom_range(0, 7) != 0);
            ENT    = ($urandom_range(0, 7) != 0);
            D      = 12'($urandom_range(0, 15) == 0 ? 12'hFFE : $urandom());
            #1;
            if (!CLR_n) begin m_p = 0; m_a = 0; end
            tick();
            checks++;
            if (q_p !== m_p[11:0] || rco_p !== exp_rco(m_p) || sel_p !== 2'((m_p >> 4) & 3))
                begin failures++; $display("FAIL rand_plain cyc=%0d q=%h rco=%b want %h/%b", i, q_p, rco_p, m_p[11:0], exp_rco(m_p)); end
            checks++;
            if (q_a !== m_a[11:0] || rco_a !== exp_rco(m_a) || sel_a !== 2'(m_a & 3))
                begin failures++; $display("FAIL rand_ar cyc=%0d q=%h rco=%b want %h/%b", i, q_a, rco_a, m_a[11:0], exp_rco(m_a)); end
        end
        CLR_n = 1'b1; LOAD_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        CLR_n = 1'b0; LOAD_n = 1'b1; ENP = 1'b0; ENT = 1'b0; D = '0;
        @(negedge CLK);
        test_reset();
        test_chain_carry();
        test_enables();
        test_auto_reload();
        test_simultaneous();
        test_sel_tap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
